// File: rtl/pipe_pkg.sv
// Shared pipeline types: operand forward-select encodings and the hazard tracker record.
// The EX-stage operand mux decodes the same encodings through ex_fwd_mux.
package pipe_pkg;

    // Widest register address the tracker record can hold; narrower addresses are zero-extended.
    localparam int MAX_REG_AW = 8;

    typedef enum logic [1:0] {
        FWD_ID_EX  = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } track_entry_t;

    localparam track_entry_t ENTRY_BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0, mem_read: 1'b0};

    // The youngest producer wins, so an EX match outranks a MEM match.
    function automatic fwd_sel_e pick_fwd(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EX_MEM;
        else if (mem_hit)
            return FWD_MEM_WB;
        else
            return FWD_ID_EX;
    endfunction

    function automatic logic [31:0] ex_fwd_mux(input logic [1:0]  sel,
                                               input logic [31:0] id_ex_val,
                                               input logic [31:0] ex_mem_val,
                                               input logic [31:0] mem_wb_val);
        case (sel)
            FWD_EX_MEM: return ex_mem_val;
            FWD_MEM_WB: return mem_wb_val;
            default:    return id_ex_val;
        endcase
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source operand against one tracker entry's destination.
// Register 0 and unused operands never match.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic                  entry_valid,
    input  logic [MAX_REG_AW-1:0] entry_rd,
    input  logic                  entry_reg_write,
    input  logic [REG_AW-1:0]     op_addr,
    input  logic                  op_used,
    output logic                  match
);

    logic [MAX_REG_AW-1:0] op_ext;

    always_comb begin
        op_ext             = '0;
        op_ext[REG_AW-1:0] = op_addr;
    end

    assign match = op_used && entry_valid && entry_reg_write &&
                   (entry_rd != '0) && (entry_rd == op_ext);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, flush and forward-select control for a 5-stage pipeline.
// Tracks the EX/MEM/WB destinations and counts stall and branch-flush cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      br_flush,
    output logic                      stall,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic                      flush_ex_mem,
    output logic [NUM_SRC*2-1:0]      ex_fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    track_entry_t                  trk [3];
    track_entry_t                  id_entry;
    logic [2:0][NUM_SRC-1:0]       hit;
    logic                          hazard;
    logic                          ex_load;
    logic [NUM_SRC*2-1:0]          fwd_next;
    logic                          unused_wb_load;

    // The WB load flag only travels along with the record; nothing downstream consumes it.
    assign unused_wb_load = trk[WB].mem_read;

    always_comb begin
        id_entry                    = ENTRY_BUBBLE;
        id_entry.valid              = 1'b1;
        id_entry.rd[REG_AW-1:0]     = id_rd_addr;
        id_entry.reg_write          = id_reg_write;
        id_entry.mem_read           = id_mem_read;
    end

    for (genvar e = 0; e < 3; e++) begin : g_stage
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
            hazard_match #(.REG_AW(REG_AW)) u_match (
                .entry_valid     (trk[e].valid),
                .entry_rd        (trk[e].rd),
                .entry_reg_write (trk[e].reg_write),
                .op_addr         (id_rs_addr[i*REG_AW +: REG_AW]),
                .op_used         (id_rs_used[i]),
                .match           (hit[e][i])
            );
        end
    end

    // With forwarding only a load in EX is unresolvable; without it any in-flight producer is.
    always_comb begin
        if (FWD_EN != 0)
            hazard = (|hit[EX]) && trk[EX].mem_read;
        else
            hazard = (|hit[EX]) || (|hit[MEM]) || (|hit[WB]);
    end

    assign stall        = id_valid && !br_flush && hazard;
    assign flush_if_id  = br_flush;
    assign flush_id_ex  = br_flush;
    assign flush_ex_mem = br_flush;
    assign ex_load      = id_valid && !stall && !br_flush;

    always_comb begin
        fwd_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (FWD_EN != 0)
                fwd_next[i*2 +: 2] = pick_fwd(hit[EX][i], hit[MEM][i]);
            else
                fwd_next[i*2 +: 2] = FWD_ID_EX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk[EX]    <= ENTRY_BUBBLE;
            trk[MEM]   <= ENTRY_BUBBLE;
            trk[WB]    <= ENTRY_BUBBLE;
            ex_fwd_sel <= '0;
        end else begin
            trk[WB]  <= trk[MEM];
            trk[MEM] <= br_flush ? ENTRY_BUBBLE : trk[EX];
            if (ex_load) begin
                trk[EX]    <= id_entry;
                ex_fwd_sel <= fwd_next;
            end else begin
                trk[EX]    <= ENTRY_BUBBLE;
                ex_fwd_sel <= '0;
            end
        end
    end

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: forwarding, stall-only and 4-bit counter builds
// share one stimulus stream; each step checks the instance the scenario targets.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         id_rd_addr;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      br_flush;

    logic        stall_f, fiid_f, fide_f, fiem_f;
    logic [3:0]  sel_f;
    logic [31:0] scnt_f, fcnt_f;
    logic        stall_s, fiid_s, fide_s, fiem_s;
    logic [3:0]  sel_s;
    logic [31:0] scnt_s, fcnt_s;
    logic        stall_c, fiid_c, fide_c, fiem_c;
    logic [3:0]  sel_c;
    logic [3:0]  scnt_c, fcnt_c;

    int num_compared   = 0;
    int num_mismatched = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_EN(1), .CNT_W(32)) dut_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .br_flush(br_flush), .stall(stall_f),
        .flush_if_id(fiid_f), .flush_id_ex(fide_f), .flush_ex_mem(fiem_f),
        .ex_fwd_sel(sel_f), .stall_cnt(scnt_f), .flush_cnt(fcnt_f)
    );

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_EN(0), .CNT_W(32)) dut_stl (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .br_flush(br_flush), .stall(stall_s),
        .flush_if_id(fiid_s), .flush_id_ex(fide_s), .flush_ex_mem(fiem_s),
        .ex_fwd_sel(sel_s), .stall_cnt(scnt_s), .flush_cnt(fcnt_s)
    );

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_EN(1), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .br_flush(br_flush), .stall(stall_c),
        .flush_if_id(fiid_c), .flush_id_ex(fide_c), .flush_ex_mem(fiem_c),
        .ex_fwd_sel(sel_c), .stall_cnt(scnt_c), .flush_cnt(fcnt_c)
    );

    task automatic apply_stimulus(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                                  input logic [1:0] used, input logic [4:0] rd,
                                  input logic rw, input logic mr, input logic bf);
        id_valid     = valid;
        id_rs_addr   = {rs1, rs0};
        id_rs_used   = used;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        br_flush     = bf;
        #1;
    endtask

    task automatic step_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_compared++;
        assert (observed === expected)
        else begin
            num_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
        step_clock();
        step_clock();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        $display("[TB] start");
        do_reset();

        // Idle after reset
        check_output("rst_stall_f", stall_f, 0);
        check_output("rst_stall_s", stall_s, 0);
        check_output("rst_flush", {fiid_f, fide_f, fiem_f}, 3'b000);
        check_output("rst_sel", sel_f, 4'b0000);
        check_output("rst_scnt", scnt_f, 0);
        check_output("rst_fcnt", fcnt_f, 0);

        // add x5 ; sub x8,x5,x6 ; and x9,x8,x5 ; or x9 ; use x9
        apply_stimulus(1, 0, 0, 2'b00, 5, 1, 0, 0);
        check_output("s1_add_stall", stall_f, 0);
        step_clock();
        apply_stimulus(1, 5, 6, 2'b11, 8, 1, 0, 0);
        check_output("s1_sub_stall", stall_f, 0);
        step_clock();
        check_output("s1_sub_sel", sel_f, 4'b0010);
        apply_stimulus(1, 8, 5, 2'b11, 9, 1, 0, 0);
        check_output("s1_and_stall", stall_f, 0);
        step_clock();
        check_output("s1_and_sel", sel_f, 4'b0110);
        apply_stimulus(1, 0, 0, 2'b00, 9, 1, 0, 0);
        step_clock();
        apply_stimulus(1, 9, 0, 2'b01, 10, 1, 0, 0);
        step_clock();
        check_output("s1_prio_sel", sel_f, 4'b0010);
        check_output("s1_scnt", scnt_f, 0);

        // ld x7 ; add x10,x7 : one-cycle load-use stall then MEM/WB forward
        do_reset();
        apply_stimulus(1, 0, 0, 2'b00, 7, 1, 1, 0);
        step_clock();
        apply_stimulus(1, 7, 0, 2'b01, 10, 1, 0, 0);
        check_output("s2_stall", stall_f, 1);
        step_clock();
        check_output("s2_scnt", scnt_f, 1);
        check_output("s2_bubble_sel", sel_f, 4'b0000);
        check_output("s2_stall_drop", stall_f, 0);
        step_clock();
        check_output("s2_sel", sel_f, 4'b0001);
        check_output("s2_scnt_hold", scnt_f, 1);

        // Stall-only build: add x3 ; or x4,x3 stalls through EX, MEM and WB
        do_reset();
        apply_stimulus(1, 0, 0, 2'b00, 3, 1, 0, 0);
        step_clock();
        apply_stimulus(1, 3, 0, 2'b01, 4, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("s3_stall_%0d", k), stall_s, 1);
            step_clock();
        end
        check_output("s3_release", stall_s, 0);
        step_clock();
        check_output("s3_sel", sel_s, 4'b0000);
        check_output("s3_scnt", scnt_s, 3);

        // Load-use coinciding with a taken branch: flush wins
        do_reset();
        apply_stimulus(1, 0, 0, 2'b00, 7, 1, 1, 0);
        step_clock();
        apply_stimulus(1, 7, 0, 2'b01, 10, 1, 0, 1);
        check_output("s4_stall", stall_f, 0);
        check_output("s4_flush", {fiid_f, fide_f, fiem_f}, 3'b111);
        step_clock();
        check_output("s4_fcnt", fcnt_f, 1);
        check_output("s4_scnt", scnt_f, 0);
        check_output("s4_sel", sel_f, 4'b0000);
        apply_stimulus(1, 7, 10, 2'b11, 11, 1, 0, 0);
        check_output("s4_no_stall", stall_f, 0);
        check_output("s4_stl_stall", stall_s, 0);
        check_output("s4_flush_clr", {fiid_f, fide_f, fiem_f}, 3'b000);
        step_clock();
        check_output("s4_bubble_sel", sel_f, 4'b0000);

        // Writes to x0 and unused operands never create hazards
        do_reset();
        apply_stimulus(1, 0, 0, 2'b00, 0, 1, 0, 0);
        step_clock();
        apply_stimulus(1, 0, 0, 2'b11, 12, 1, 0, 0);
        check_output("s5_x0_stall_f", stall_f, 0);
        check_output("s5_x0_stall_s", stall_s, 0);
        step_clock();
        check_output("s5_x0_sel", sel_f, 4'b0000);
        apply_stimulus(1, 0, 0, 2'b00, 5, 1, 1, 0);
        step_clock();
        apply_stimulus(1, 5, 5, 2'b00, 13, 1, 0, 0);
        check_output("s5_unused_f", stall_f, 0);
        check_output("s5_unused_s", stall_s, 0);
        step_clock();
        check_output("s5_unused_sel", sel_f, 4'b0000);

        // Back-to-back ld x7 reading x7: stall on every second cycle, 4-bit counter saturates
        do_reset();
        apply_stimulus(1, 7, 0, 2'b01, 7, 1, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            check_output($sformatf("s6_stall_c%0d", k), stall_c, logic'((k % 2) == 0));
            step_clock();
        end
        check_output("s6_sat", scnt_c, 4'hf);
        check_output("s6_c31", stall_c, 0);
        step_clock();
        check_output("s6_c32", stall_c, 1);
        step_clock();
        check_output("s6_sat_hold", scnt_c, 4'hf);
        check_output("s6_wide", scnt_f, 16);
        check_output("s6_c33", stall_c, 0);
        step_clock();
        check_output("s6_c34", stall_c, 1);
        reset = 1'b1;
        step_clock();
        reset = 1'b0;
        #1;
        check_output("s6_rst_scnt", scnt_c, 0);
        check_output("s6_rst_stall", stall_c, 0);
        check_output("s6_rst_sel", sel_c, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
